// File: rtl/hdl_lib_pkg.sv
// hdl_lib_pkg: shared definitions for the hdl_lib buffer RAMs.
//   ramf_state_t    : sweep/run state encoding used by ram_dp_fwd
//   ramf_lane_width : width of one write-enable lane (word width / lanes)
package hdl_lib_pkg;

    typedef enum logic {
        RAMF_SWEEP = 1'b0,
        RAMF_RUN   = 1'b1
    } ramf_state_t;

    function automatic int ramf_lane_width(input int data_w, input int lanes);
        return data_w / lanes;
    endfunction

endpackage

// File: rtl/ram_dp_core.sv
// ram_dp_core: bare simple-dual-port storage array, no reset.
// Ports:
//   i_clk      clock, rising edge
//   i_we       write strobe
//   i_be       per-lane write enable, lane i covers bits [i*LW +: LW]
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_re       read strobe; o_rd_data updates only on an accepted read
//   i_rd_addr  read address
//   o_rd_data  registered read data, read-first (old contents on a
//              same-address write), latency 1
module ram_dp_core
    import hdl_lib_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int ADDRWIDTH = 9,
    parameter int LANES     = 2
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [LANES-1:0]     i_be,
    input  logic [ADDRWIDTH-1:0] i_wr_addr,
    input  logic [DATAWIDTH-1:0] i_wr_data,
    input  logic                 i_re,
    input  logic [ADDRWIDTH-1:0] i_rd_addr,
    output logic [DATAWIDTH-1:0] o_rd_data
);

    localparam int LW = ramf_lane_width(DATAWIDTH, LANES);

    logic [DATAWIDTH-1:0] r_mem [2**ADDRWIDTH];
    logic [DATAWIDTH-1:0] r_rd_q;

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (i_we && i_be[i]) begin
                r_mem[i_wr_addr][i*LW +: LW] <= i_wr_data[i*LW +: LW];
            end
        end
        if (i_re) begin
            r_rd_q <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_q;

endmodule

// File: rtl/ram_dp_fwd.sv
// ram_dp_fwd: simple-dual-port RAM with byte-lane writes, write-to-read
// forwarding, optional output register and an initialisation sweep that
// runs after reset and on request.
// Ports:
//   i_clk      clock, rising edge
//   i_reset_l  asynchronous active-low reset
//   i_wr_data  write data
//   i_wr_addr  write address
//   i_we       write strobe
//   i_wr_be    per-lane write enable
//   i_rd_addr  read address
//   i_re       read strobe
//   o_rd_data  read data, holds between reads, 0 after reset
//   o_rd_valid one-cycle pulse with new o_rd_data, latency 1+OUTREG
//   i_clear    request a sweep (run state only; drops same-cycle we/re)
//   o_busy     sweep in progress, user accesses ignored
module ram_dp_fwd
    import hdl_lib_pkg::*;
#(
    parameter int                   DATAWIDTH = 16,
    parameter int                   ADDRWIDTH = 9,
    parameter int                   LANES     = 2,
    parameter int                   OUTREG    = 0,
    parameter logic [DATAWIDTH-1:0] INITVAL   = '1
) (
    input  logic                 i_clk,
    input  logic                 i_reset_l,
    input  logic [DATAWIDTH-1:0] i_wr_data,
    input  logic [ADDRWIDTH-1:0] i_wr_addr,
    input  logic                 i_we,
    input  logic [LANES-1:0]     i_wr_be,
    input  logic [ADDRWIDTH-1:0] i_rd_addr,
    input  logic                 i_re,
    output logic [DATAWIDTH-1:0] o_rd_data,
    output logic                 o_rd_valid,
    input  logic                 i_clear,
    output logic                 o_busy
);

    localparam int LW = ramf_lane_width(DATAWIDTH, LANES);

    if (DATAWIDTH % LANES != 0) begin : g_bad_lanes
        $error("ram_dp_fwd: DATAWIDTH must be a multiple of LANES");
    end

    ramf_state_t          r_state, w_state_nxt;
    logic [ADDRWIDTH:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                 w_wr_acc, w_rd_acc;
    logic                 w_core_we;
    logic [LANES-1:0]     w_core_be;
    logic [ADDRWIDTH-1:0] w_core_addr;
    logic [DATAWIDTH-1:0] w_core_wdata;
    logic [DATAWIDTH-1:0] w_core_q;
    logic [LANES-1:0]     w_fwd_mask;
    logic [DATAWIDTH-1:0] w_rd_merged;

    logic                 r_vld_p1;
    logic [LANES-1:0]     r_fwd_mask_p1;
    logic [DATAWIDTH-1:0] r_fwd_data_p1;

    // Counter MSB set means the last address has just been written.
    assign w_cnt_inc = r_cnt + {{ADDRWIDTH{1'b0}}, 1'b1};

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_wr_acc     = 1'b0;
        w_rd_acc     = 1'b0;
        w_core_we    = 1'b0;
        w_core_be    = '0;
        w_core_addr  = i_wr_addr;
        w_core_wdata = i_wr_data;
        case (r_state)
            RAMF_SWEEP: begin
                w_core_we    = 1'b1;
                w_core_be    = '1;
                w_core_addr  = r_cnt[ADDRWIDTH-1:0];
                w_core_wdata = INITVAL;
                w_cnt_nxt    = w_cnt_inc;
                if (w_cnt_inc[ADDRWIDTH]) begin
                    w_state_nxt = RAMF_RUN;
                end
            end
            RAMF_RUN: begin
                if (i_clear) begin
                    w_state_nxt = RAMF_SWEEP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_wr_acc  = i_we;
                    w_rd_acc  = i_re;
                    w_core_we = i_we;
                    w_core_be = i_wr_be;
                end
            end
            default: begin
                w_state_nxt = RAMF_SWEEP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_l) begin
        if (!i_reset_l) begin
            r_state <= RAMF_SWEEP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_busy = (r_state == RAMF_SWEEP);

    ram_dp_core #(
        .DATAWIDTH (DATAWIDTH),
        .ADDRWIDTH (ADDRWIDTH),
        .LANES     (LANES)
    ) u_core (
        .i_clk     (i_clk),
        .i_we      (w_core_we),
        .i_be      (w_core_be),
        .i_wr_addr (w_core_addr),
        .i_wr_data (w_core_wdata),
        .i_re      (w_rd_acc),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (w_core_q)
    );

    // Core is read-first: lanes written at the read address in the same
    // cycle are overlaid from the captured write data.
    assign w_fwd_mask = (w_wr_acc && (i_wr_addr == i_rd_addr)) ? i_wr_be : '0;

    // ---- stage p1: read issued, forwarding captured ----
    always_ff @(posedge i_clk or negedge i_reset_l) begin
        if (!i_reset_l) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_rd_acc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_rd_acc) begin
            r_fwd_mask_p1 <= w_fwd_mask;
            r_fwd_data_p1 <= i_wr_data;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_rd_merged[g*LW +: LW] = r_fwd_mask_p1[g] ? r_fwd_data_p1[g*LW +: LW]
                                                          : w_core_q[g*LW +: LW];
    end

    // ---- stage p2: optional output register ----
    if (OUTREG != 0) begin : g_outreg
        logic                 r_vld_p2;
        logic [DATAWIDTH-1:0] r_rd_data_p2;

        always_ff @(posedge i_clk or negedge i_reset_l) begin
            if (!i_reset_l) begin
                r_vld_p2     <= 1'b0;
                r_rd_data_p2 <= '0;
            end else begin
                r_vld_p2 <= r_vld_p1;
                if (r_vld_p1) begin
                    r_rd_data_p2 <= w_rd_merged;
                end
            end
        end

        assign o_rd_data  = r_rd_data_p2;
        assign o_rd_valid = r_vld_p2;
    end else begin : g_direct
        // Core and forwarding registers only load on a read, so they hold
        // naturally; this flag forces zero until the first read after reset.
        logic r_seen_p1;

        always_ff @(posedge i_clk or negedge i_reset_l) begin
            if (!i_reset_l) begin
                r_seen_p1 <= 1'b0;
            end else if (w_rd_acc) begin
                r_seen_p1 <= 1'b1;
            end
        end

        assign o_rd_data  = r_seen_p1 ? w_rd_merged : '0;
        assign o_rd_valid = r_vld_p1;
    end

endmodule

// File: doc/ram_dp_fwd.md
# ram_dp_fwd

Parameterized simple-dual-port RAM with byte-lane write enables, explicit write-to-read forwarding, a selectable output register, and a hardware initialisation sweep. The sweep runs after reset and on request. It is the general-purpose buffer RAM for FIFOs, lookup tables and packet buffers in the hdl_lib library. Forwarding is done in RTL, so results do not depend on vendor RAM inference.

## Interface
- DATAWIDTH, 16, word width; must be a multiple of LANES
- ADDRWIDTH, 9, address width; depth = 2^ADDRWIDTH
- LANES, 2, number of write-enable lanes; lane width LW = DATAWIDTH/LANES
- OUTREG, 0, 1 adds an output register stage
- INITVAL, all ones, value the sweep writes to every word

- clk  in  1  clock; all logic on rising edge
- reset_l  in  1  asynchronous, active-low reset
- wr_data  in  DATAWIDTH  write data
- wr_addr  in  ADDRWIDTH  write address
- we  in  1  write strobe
- wr_be  in  LANES  per-lane write enable; lane i covers bits [i*LW +: LW]
- rd_addr  in  ADDRWIDTH  read address
- re  in  1  read strobe
- rd_data  out  DATAWIDTH  read data; holds its value between reads
- rd_valid  out  1  one-cycle pulse, coincident with new rd_data
- clear  in  1  request an initialisation sweep
- busy  out  1  sweep in progress; user accesses are ignored while high

## Operation
- FSM states are SWEEP and RUN. Reset enters SWEEP with sweep counter = 0.
- SWEEP:
  - Each cycle, write INITVAL to all lanes at the counter address, then increment the counter.
  - After address 2^ADDRWIDTH-1 is written, go to RUN.
  - we, re and clear are ignored.
- RUN, write: if we is high, write the lanes where wr_be[i]=1. Lanes with wr_be[i]=0 keep their old contents. we with wr_be=0 is a no-op.
- RUN, read: if re is high, capture rd_addr.
  - Returned data = memory contents after this cycle's write, i.e. new data.
  - If we && wr_addr==rd_addr in the same cycle, lanes with wr_be set return wr_data; the other lanes return stored data.
  - Writes in later cycles never change a read already issued.
- RUN, clear: go to SWEEP with counter = 0.
  - clear has priority; we and re in that same cycle are dropped.
  - Reads already issued complete normally.
- rd_data changes only when rd_valid is high.

## Timing
- Read latency L = 1 + OUTREG.
  - re sampled at edge N gives rd_valid=1 and the data during cycle N+L.
  - Full throughput: one read per cycle.
- Write is visible to a read issued in the same cycle (forwarding) and to all later reads.
- Sweep length is 2^ADDRWIDTH cycles.
  - After reset deasserts, busy=1 for exactly 2^ADDRWIDTH cycles.
  - The first user access is accepted on the next edge.
  - After clear in RUN, busy rises on the following cycle and stays high for 2^ADDRWIDTH cycles.
- Reset values: busy=1, rd_valid=0, rd_data=0, sweep counter=0, pipeline valid bits=0.
- Reset asserted mid-sweep or mid-read:
  - Pipeline flushes; no rd_valid for in-flight reads.
  - Sweep restarts from address 0.
- Sweep counter is ADDRWIDTH+1 bits wide; the MSB marks completion, so there is no wrap-around ambiguity.
- rd_addr==wr_addr with we=1 and re=0: plain write, nothing forwarded.

## Structure
- Shared package hdl_lib_pkg holds:
  - FSM state encodings RAMF_SWEEP and RAMF_RUN
  - a function computing LW from DATAWIDTH/LANES, with an elaboration-time check that DATAWIDTH % LANES == 0
- Sub-module ram_dp_core: bare storage array.
  - One write port with per-lane enables.
  - Synchronous read-first read port, latency 1.
  - No reset.
- ram_dp_fwd wraps ram_dp_core and adds:
  - sweep FSM and mux onto the write port
  - address-compare and lane-merge forwarding register
  - optional OUTREG stage and rd_valid pipeline

## Test plan
All scenarios use DATAWIDTH=16, ADDRWIDTH=4, LANES=2, INITVAL=16'hFFFF, unless stated otherwise.
- Reset then idle: busy=1 for 16 cycles then 0. Reading addresses 0..15 afterwards returns 16'hFFFF each, with rd_valid one cycle after each re.
- Same-cycle forwarding: addr 3 holds 16'h1234. Then we, wr_be=2'b01, wr_data=16'hAB56 with re at addr 3 in the same cycle → rd_data=16'h1256. A later read of addr 3 → 16'h1256.
- Read isolation: read addr 5 (holds 16'h0000) at cycle N, write 16'hBEEF to addr 5 at N+1 → rd_data=16'h0000 at N+1. Repeat with OUTREG=1: the value 16'h0000 appears at N+2.
- Back-to-back reads of addresses 0,1,2 on consecutive cycles → rd_valid high for 3 consecutive cycles with the matching data. With re deasserted afterwards, rd_data holds the last value.
- clear after writing 16'h0001 to addr 7: the same-cycle write to addr 8 is dropped, busy is high 16 cycles, and addr 7 and addr 8 both read 16'hFFFF afterwards.
- reset_l pulsed low at sweep count 9 while a read is in flight → no rd_valid, and busy stays high 16 full cycles after release.
